// File: rtl/sigmoid_sched_pkg.sv
// Shared definitions for the sigmoid scheduler and the sigmoid unit it feeds.
package sigmoid_sched_pkg;

  // Default datapath widths, common with the sigmoid unit.
  localparam int IBIT_DEF = 32;
  localparam int OBIT_DEF = 11;
  localparam int FBIT_DEF = 10;

  // Smallest watchdog that still outlasts a healthy sigmoid computation.
  localparam int MIN_TIMEOUT = FBIT_DEF + 7;

  // Scheduler states.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_GAP    = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/sigmoid_sched_rr_arbiter.sv
// Combinational round-robin search: first requester at or after ptr, wrapping.
module rr_arbiter
  import sigmoid_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [IDW-1:0]  gnt,
  output logic            any_req
);

  logic [IDW:0] idx;

  // Scan from the farthest offset down so the nearest requester wins.
  always_comb begin
    gnt     = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IDW + 1)'(k);
      if (idx >= (IDW + 1)'(NREQ)) begin
        idx = idx - (IDW + 1)'(NREQ);
      end
      if (req[idx[IDW-1:0]]) begin
        gnt     = idx[IDW-1:0];
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sigmoid_sched.sv
// Round-robin scheduler sharing one sigmoid unit among NREQ requesters,
// with a watchdog that returns an error result if the unit never answers.
module sigmoid_sched
  import sigmoid_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int IBIT    = IBIT_DEF,
  parameter int OBIT    = OBIT_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*IBIT-1:0]   req_data,
  output logic [NREQ-1:0]        ack,
  output logic                   res_valid,
  output logic [IDW-1:0]         res_id,
  output logic signed [OBIT-1:0] res_data,
  output logic                   res_err,
  output logic                   busy,
  output logic                   sig_dv_in,
  output logic signed [IBIT-1:0] sig_in,
  input  logic                   sig_dv_out,
  input  logic signed [OBIT-1:0] sig_out
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t                 state;
  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         cur_id;
  logic [TW-1:0]          timer;
  logic [IDW-1:0]         gnt;
  logic                   any_req;
  logic signed [IBIT-1:0] sel_data;
  logic [IDW-1:0]         next_ptr;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .any_req (any_req)
  );

  // Operand of the granted requester and the pointer just past it.
  always_comb begin
    sel_data = req_data[IBIT-1:0];
    for (int i = 0; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        sel_data = req_data[i*IBIT +: IBIT];
      end
    end
    next_ptr = (gnt == IDW'(NREQ - 1)) ? '0 : gnt + IDW'(1);
  end

  // Scheduler FSM; every output is registered on entry to the state it marks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      timer     <= '0;
      ack       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
      res_err   <= 1'b0;
      busy      <= 1'b0;
      sig_dv_in <= 1'b0;
      sig_in    <= '0;
    end else begin
      ack       <= '0;
      res_valid <= 1'b0;
      sig_dv_in <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            ack[gnt]  <= 1'b1;
            sig_in    <= sel_data;
            cur_id    <= gnt;
            rr_ptr    <= next_ptr;
            sig_dv_in <= 1'b1;
            busy      <= 1'b1;
            state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          timer <= '0;
          state <= S_GAP;
        end
        // Forces a low cycle on the strobe before any later rising edge.
        S_GAP: begin
          state <= S_WAIT;
        end
        // sig_in stays put: the unit re-reads the operand sign at the end.
        S_WAIT: begin
          timer <= timer + TW'(1);
          if (sig_dv_out) begin
            res_data  <= sig_out;
            res_err   <= 1'b0;
            res_id    <= cur_id;
            res_valid <= 1'b1;
            state     <= S_RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            res_data  <= '0;
            res_err   <= 1'b1;
            res_id    <= cur_id;
            res_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sigmoid_sched.sv
// Bench for sigmoid_sched: stub sigmoid unit, timeline reference model,
// directed scenarios and a randomized requester phase.
module tb_sigmoid_sched;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int IBIT    = 32;
  localparam int OBIT    = 11;
  localparam int TIMEOUT = 64;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*IBIT-1:0]   req_data;
  logic [NREQ-1:0]        ack;
  logic                   res_valid;
  logic [IDW-1:0]         res_id;
  logic signed [OBIT-1:0] res_data;
  logic                   res_err;
  logic                   busy;
  logic                   sig_dv_in;
  logic signed [IBIT-1:0] sig_in;
  logic                   sig_dv_out;
  logic signed [OBIT-1:0] sig_out;

  sigmoid_sched #(
    .NREQ(NREQ), .IDW(IDW), .IBIT(IBIT), .OBIT(OBIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .ack(ack),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data),
    .res_err(res_err), .busy(busy), .sig_dv_in(sig_dv_in), .sig_in(sig_in),
    .sig_dv_out(sig_dv_out), .sig_out(sig_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_dvin = 0;
  int n_resv = 0;
  int glog[$];

  // stub controls
  bit stub_en = 1'b1;
  bit spur_en = 1'b0;
  bit rand_lat = 1'b0;
  int lat_fix = 8;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Crude hard-sigmoid with 1.0 = 1024: 0.5 at zero, slope 1/4, clamped.
  function automatic logic [OBIT-1:0] fsig(input logic signed [IBIT-1:0] x);
    longint y;
    y = 64'sd512 + longint'(x >>> 2);
    if (y < 0) y = 0;
    if (y > 1023) y = 1023;
    return OBIT'(y);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Stub sigmoid unit: answers lat cycles after a rising strobe edge.
  initial begin : stub
    int cnt;
    bit prev;
    cnt = 0;
    prev = 1'b0;
    sig_dv_out = 1'b0;
    sig_out = '0;
    forever begin
      @(posedge clk);
      #1;
      sig_dv_out = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          sig_dv_out = 1'b1;
          sig_out = fsig(sig_in);
        end
      end else if (spur_en && $urandom_range(0, 31) == 0) begin
        sig_dv_out = 1'b1;
        sig_out = OBIT'($urandom);
      end
      if (stub_en && sig_dv_in && !prev) begin
        if (rand_lat)
          cnt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(60, 70))
                                            : int'($urandom_range(2, 20));
        else
          cnt = lat_fix;
      end
      prev = sig_dv_in;
    end
  end

  // Reference model: timeline of one operation measured from its launch cycle.
  initial begin : model
    bit m_busy;
    int m_t, m_resp_at, m_pend, m_ptr, m_id;
    logic signed [IBIT-1:0] m_op, m_sigin, p_op;
    logic signed [OBIT-1:0] r_data, h_data;
    logic r_err, h_err;
    logic [IDW-1:0] h_id;
    logic [NREQ-1:0] eack;
    logic edv, erv;
    m_busy = 0; m_t = 0; m_resp_at = -1; m_pend = -1; m_ptr = 0; m_id = 0;
    m_op = '0; m_sigin = '0; p_op = '0; r_data = '0; h_data = '0;
    r_err = 0; h_err = 0; h_id = '0;
    forever begin
      @(negedge clk);
      if (ack != 0) begin
        for (int i = 0; i < NREQ; i++) if (ack[i]) glog.push_back(i);
      end
      if (sig_dv_in) n_dvin++;
      if (res_valid) n_resv++;
      if (!rst_n) begin
        m_busy = 0; m_pend = -1; m_ptr = 0; m_sigin = '0;
        h_id = '0; h_data = '0; h_err = 0;
        chk("rst_ack", 64'(ack), 0);
        chk("rst_res_valid", 64'(res_valid), 0);
        chk("rst_res_id", 64'(res_id), 0);
        chk("rst_res_data", 64'(res_data), 0);
        chk("rst_res_err", 64'(res_err), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_sig_dv_in", 64'(sig_dv_in), 0);
        chk("rst_sig_in", 64'(sig_in), 0);
      end else begin
        if (m_pend >= 0) begin
          m_busy = 1; m_t = 0; m_resp_at = -1; m_id = m_pend;
          m_op = p_op; m_sigin = p_op; m_pend = -1;
        end
        eack = '0;
        if (m_busy && m_t == 0) eack[m_id] = 1'b1;
        edv = m_busy && (m_t == 0);
        erv = m_busy && (m_t == m_resp_at);
        if (erv) begin
          h_id = IDW'(m_id); h_data = r_data; h_err = r_err;
        end
        chk("ack", 64'(ack), 64'(eack));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("sig_dv_in", 64'(sig_dv_in), 64'(edv));
        chk("res_valid", 64'(res_valid), 64'(erv));
        chk("res_id", 64'(res_id), 64'(h_id));
        chk("res_data", 64'(res_data), 64'(h_data));
        chk("res_err", 64'(res_err), 64'(h_err));
        chk("sig_in", 64'(sig_in), 64'(m_sigin));
        if (m_busy) begin
          if (m_t == m_resp_at) begin
            m_busy = 0;
          end else if (m_resp_at < 0 && m_t >= 2) begin
            if (sig_dv_out) begin
              m_resp_at = m_t + 1; r_data = sig_out; r_err = 0;
            end else if (m_t == TIMEOUT + 1) begin
              m_resp_at = m_t + 1; r_data = '0; r_err = 1;
            end
          end
          m_t++;
        end else if (req != 0) begin
          for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (req[idx] && m_pend < 0) m_pend = idx;
          end
          p_op = req_data[m_pend*IBIT +: IBIT];
          m_ptr = (m_pend + 1) % NREQ;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [IBIT-1:0] d);
    req_data[i*IBIT +: IBIT] = d;
    req[i] = 1'b1;
  endtask

  task automatic wait_ack(input int i, output int at);
    bit found;
    found = 0;
    at = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      step();
      if (ack[i]) begin
        found = 1; at = cyc; req[i] = 1'b0;
      end
    end
    if (!found) chk("ack_wait_expired", 0, 1);
  endtask

  task automatic wait_resp(output int at);
    bit found;
    found = 0;
    at = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      step();
      if (res_valid) begin
        found = 1; at = cyc;
      end
    end
    if (!found) chk("resp_wait_expired", 0, 1);
  endtask

  task automatic wait_idle();
    bit found;
    found = 0;
    for (int n = 0; n < 300 && !found; n++) begin
      step();
      if (!busy) found = 1;
    end
    if (!found) chk("idle_wait_expired", 0, 1);
  endtask

  initial begin : directed
    int ca, cr, d0, r0, g;
    bit seen1, seen3;
    rst_n = 1'b0;
    req = '0;
    req_data = '0;
    repeat (3) step();
    chk("reset_busy", 64'(busy), 0);
    chk("reset_sig_in", 64'(sig_in), 0);
    rst_n = 1'b1;
    step();

    // single operation with operand 0
    d0 = n_dvin;
    set_req(0, 32'd0);
    wait_ack(0, ca);
    wait_resp(cr);
    chk("t1_res_id", 64'(res_id), 0);
    chk("t1_res_data", 64'(res_data), 512);
    chk("t1_res_err", 64'(res_err), 0);
    chk("t1_dvin_cycles", 64'(n_dvin - d0), 1);

    // saturating operands
    wait_idle();
    set_req(2, 32'd4096);
    wait_ack(2, ca);
    wait_resp(cr);
    chk("t2_pos_id", 64'(res_id), 2);
    chk("t2_pos_data", 64'(res_data), 1023);
    wait_idle();
    set_req(1, 32'hFFFF_F000);
    wait_ack(1, ca);
    wait_resp(cr);
    chk("t2_neg_id", 64'(res_id), 1);
    chk("t2_neg_data", 64'(res_data), 0);

    // contention from a fresh pointer
    wait_idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    glog.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, IBIT'(100 + 1000 * i));
    for (int n = 0; n < 400 && glog.size() < 5; n++) step();
    req = '0;
    chk("t3_grants", 64'(glog.size()), 5);
    if (glog.size() >= 5) begin
      chk("t3_g0", 64'(glog[0]), 0);
      chk("t3_g1", 64'(glog[1]), 1);
      chk("t3_g2", 64'(glog[2]), 2);
      chk("t3_g3", 64'(glog[3]), 3);
      chk("t3_g4", 64'(glog[4]), 0);
    end
    wait_resp(cr);
    chk("t3_last_id", 64'(res_id), 0);
    chk("t3_last_data", 64'(res_data), 64'(fsig(32'sd100)));

    // watchdog timeout then normal service
    wait_idle();
    stub_en = 1'b0;
    set_req(3, 32'd55);
    wait_ack(3, ca);
    wait_resp(cr);
    chk("t4_latency", 64'(cr - ca), 64'(TIMEOUT + 2));
    chk("t4_err", 64'(res_err), 1);
    chk("t4_data", 64'(res_data), 0);
    chk("t4_id", 64'(res_id), 3);
    stub_en = 1'b1;
    wait_idle();
    set_req(0, 32'd0);
    wait_ack(0, ca);
    wait_resp(cr);
    chk("t4_after_err", 64'(res_err), 0);
    chk("t4_after_data", 64'(res_data), 512);

    // asynchronous reset in the middle of a computation
    wait_idle();
    lat_fix = 20;
    set_req(2, 32'd7);
    wait_ack(2, ca);
    repeat (5) step();
    #1 rst_n = 1'b0;
    #1;
    chk("t5_async_busy", 64'(busy), 0);
    chk("t5_async_sig_in", 64'(sig_in), 0);
    chk("t5_async_outs", 64'({ack, res_valid, res_id, res_data, res_err, sig_dv_in}), 0);
    step();
    rst_n = 1'b1;
    r0 = n_resv;
    repeat (30) step();
    chk("t5_late_ignored", 64'(n_resv - r0), 0);
    glog.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, IBIT'(i));
    for (int n = 0; n < 50 && glog.size() < 1; n++) step();
    req = '0;
    g = (glog.size() > 0) ? glog[0] : -1;
    chk("t5_first_grant", 64'(g), 0);
    lat_fix = 5;

    // withdrawal and fairness
    wait_idle();
    glog.delete();
    set_req(0, 32'd11);
    set_req(1, 32'd22);
    for (int n = 0; n < 50 && glog.size() < 1; n++) begin
      step();
      if (ack[1]) req[1] = 1'b0;
    end
    step();
    set_req(3, 32'd33);
    step();
    req[3] = 1'b0;
    for (int n = 0; n < 200 && glog.size() < 4; n++) begin
      step();
      if (ack[1]) req[1] = 1'b0;
    end
    req = '0;
    seen1 = 0;
    seen3 = 0;
    for (int i = 0; i < glog.size(); i++) begin
      if (glog[i] == 1 && i < 2) seen1 = 1;
      if (glog[i] == 3) seen3 = 1;
    end
    chk("t6_fair_req1", 64'(seen1), 1);
    chk("t6_withdrawn_req3", 64'(seen3), 0);
    wait_idle();

    // randomized requesters against the model
    spur_en = 1'b1;
    rand_lat = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && ack[i]) begin
          if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
          else req_data[i*IBIT +: IBIT] = $urandom;
        end else if (!req[i] && $urandom_range(0, 7) == 0) begin
          set_req(i, $urandom);
        end else if (req[i] && $urandom_range(0, 63) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    req = '0;
    spur_en = 1'b0;
    repeat (200) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
